// File: rtl/wallclock_set_controller.sv
// WallClock controller: 1 s prescaler, button-driven time-set FSM (RUN/SET_HOURS/SET_MINUTES)
// with a one-cycle load strobe on exit and a blink phase for the field being edited.
module wallclock_set_controller #(
  parameter int TICK_DIV   = 100000000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       tick_1s,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] mode,
  output logic       blink_hours,
  output logic       blink_minutes
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    sync1, sync2, sync3, press;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          press_mode, step_up, step_dn;

  // Bit order {dec, inc, mode}; sync regs reset high so a button held through reset is not a press.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
      press <= '0;
    end else begin
      sync1 <= {btn_dec, btn_inc, btn_mode};
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync2 & ~sync3;
    end
  end

  assign press_mode = press[0];
  assign step_up    = press[1] & ~press[2] & ~press[0];
  assign step_dn    = press[2] & ~press[1] & ~press[0];

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state        <= RUN;
      load         <= 1'b0;
      load_hours   <= '0;
      load_minutes <= '0;
      presc        <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (press_mode) begin
            state        <= SET_HOURS;
            load_hours   <= (cur_hours > 5'd23) ? 5'd0 : cur_hours;
            load_minutes <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
          end
        end
        SET_HOURS: begin
          if (press_mode)   state <= SET_MINUTES;
          else if (step_up) load_hours <= (load_hours == 5'd23) ? 5'd0 : load_hours + 5'd1;
          else if (step_dn) load_hours <= (load_hours == 5'd0) ? 5'd23 : load_hours - 5'd1;
        end
        SET_MINUTES: begin
          if (press_mode) begin
            state <= RUN;
            load  <= 1'b1;
          end
          else if (step_up) load_minutes <= (load_minutes == 6'd59) ? 6'd0 : load_minutes + 6'd1;
          else if (step_dn) load_minutes <= (load_minutes == 6'd0) ? 6'd59 : load_minutes - 6'd1;
        end
        default: state <= RUN;
      endcase

      // Time is frozen outside RUN; leaving set mode restarts the second from zero.
      if (state == RUN && !press_mode)
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      else
        presc <= '0;

      if (press_mode) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign tick_1s       = (state == RUN) && (presc == PRESC_LAST);
  assign load_seconds  = 6'd0;
  assign mode          = state;
  assign blink_hours   = (state == SET_HOURS) && blink_phase;
  assign blink_minutes = (state == SET_MINUTES) && blink_phase;

endmodule

// File: tb/tb_wallclock_set_controller.sv
// Directed bench for wallclock_set_controller with TICK_DIV=10, BLINK_HALF=4.
module tb_wallclock_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       tick_1s, load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes, load_seconds;
  logic [1:0] mode;
  logic       blink_hours, blink_minutes;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;
  int set_ticks = 0;
  int load_in_reset = 0;
  logic [4:0] cap_h;
  logic [5:0] cap_m, cap_s;

  localparam int B_MODE = 1, B_INC = 2, B_DEC = 4;

  wallclock_set_controller #(.TICK_DIV(10), .BLINK_HALF(4)) dut (
    .CLK100MHZ(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .tick_1s(tick_1s), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .mode(mode), .blink_hours(blink_hours), .blink_minutes(blink_minutes)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      cap_h = load_hours;
      cap_m = load_minutes;
      cap_s = load_seconds;
      if (reset) load_in_reset++;
    end
    if (tick_1s && mode != 2'd0) set_ticks++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise buttons; the FSM reacts on the 4th edge after the raise. Returns just after that edge.
  task automatic press(input int mask, input bit settle);
    btn_mode = mask[0];
    btn_inc  = mask[1];
    btn_dec  = mask[2];
    repeat (4) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    if (settle) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first_tick, prev_tick, bad_gap, nticks;
    reset = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hours = 5'd13; cur_minutes = 6'd45;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_tick", tick_1s, 0);
    check("rst_load", load, 0);
    check("rst_lh", load_hours, 0);
    check("rst_blink", {blink_hours, blink_minutes}, 0);

    // 1: 100 RUN cycles give 10 ticks, 10 apart
    @(posedge clk); #1;
    reset = 1'b0;
    first_tick = -1; prev_tick = -1; bad_gap = 0; nticks = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tick_1s) begin
        if (first_tick < 0) first_tick = k;
        if (prev_tick >= 0 && k - prev_tick != 10) bad_gap++;
        prev_tick = k;
        nticks++;
      end
    end
    check("t1_ticks", nticks, 10);
    check("t1_first", first_tick, 9);
    check("t1_gaps", bad_gap, 0);
    check("t1_load", load_cnt, 0);
    @(posedge clk); #1;

    // 2: edit 13:45 -> 16:43
    press(B_MODE, 1);
    check("t2_mode1", mode, 1);
    check("t2_caph", load_hours, 13);
    check("t2_capm", load_minutes, 45);
    repeat (3) press(B_INC, 1);
    check("t2_inc", load_hours, 16);
    press(B_MODE, 1);
    check("t2_mode2", mode, 2);
    repeat (2) press(B_DEC, 1);
    check("t2_dec", load_minutes, 43);
    check("t2_noload", load_cnt, 0);
    press(B_MODE, 1);
    check("t2_mode0", mode, 0);
    check("t2_loadcnt", load_cnt, 1);
    check("t2_ldh", cap_h, 16);
    check("t2_ldm", cap_m, 43);
    check("t2_lds", cap_s, 0);
    check("t2_setticks", set_ticks, 0);

    // 3: wrap 23:00 -> 00:59
    cur_hours = 5'd23; cur_minutes = 6'd0;
    press(B_MODE, 1);
    check("t3_caph", load_hours, 23);
    press(B_INC, 1);
    check("t3_hwrap", load_hours, 0);
    press(B_MODE, 1);
    press(B_DEC, 1);
    check("t3_mwrap", load_minutes, 59);
    press(B_MODE, 1);
    check("t3_loadcnt", load_cnt, 2);
    check("t3_ldh", cap_h, 0);
    check("t3_ldm", cap_m, 59);

    // 4: inc+dec together ignored; mode+inc in RUN drops inc
    cur_hours = 5'd5; cur_minutes = 6'd10;
    press(B_MODE, 1);
    press(B_INC | B_DEC, 1);
    check("t4_both", load_hours, 5);
    press(B_MODE, 1);
    press(B_MODE, 1);
    check("t4_loadcnt", load_cnt, 3);
    check("t4_ldh", cap_h, 5);
    check("t4_ldm", cap_m, 10);
    cur_hours = 5'd7; cur_minutes = 6'd20;
    press(B_MODE | B_INC, 1);
    check("t4_mode_inc", mode, 1);
    check("t4_capnoinc", load_hours, 7);
    press(B_MODE, 1);
    press(B_MODE, 1);
    check("t4_loadcnt2", load_cnt, 4);
    check("t4_ldh2", cap_h, 7);

    // 6: blink phase, 4 cycles off then 4 on, restarting on mode change
    press(B_MODE, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6_blink_h", blink_hours, (i / 4) % 2);
      check("t6_blink_m0", blink_minutes, 0);
    end
    @(posedge clk); #1;
    press(B_MODE, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_blink_m", blink_minutes, (i / 4) % 2);
      check("t6_blink_h0", blink_hours, 0);
    end
    @(posedge clk); #1;
    press(B_MODE, 1);
    check("t6_loadcnt", load_cnt, 5);

    // 5: mode held across reset release; reset mid-edit
    reset = 1'b1;
    btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_held", mode, 0);
    @(posedge clk); #1;
    cur_hours = 5'd9; cur_minutes = 6'd30;
    press(B_MODE, 1);
    press(B_MODE, 1);
    check("t5_setm", mode, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_rstmode", mode, 0);
    check("t5_rstlh", load_hours, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t5_noload", load_cnt, 5);
    check("t5_loadrst", load_in_reset, 0);
    check("end_setticks", set_ticks, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
